// File: rtl/time_set_ctrl_pkg.sv
// Shared types, BCD limits and BCD step helpers for the time/alarm set front end.
package time_set_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      EDIT_H = 2'd1,
      EDIT_M = 2'd2,
      COMMIT = 2'd3
   } state_t;

   localparam int unsigned HOURS_MAX   = 23;
   localparam int unsigned MINUTES_MAX = 59;

   localparam logic [1:0] H_TENS_MAX  = 2'(HOURS_MAX / 10);
   localparam logic [3:0] H_UNITS_MAX = 4'(HOURS_MAX % 10);
   localparam logic [3:0] M_TENS_MAX  = 4'(MINUTES_MAX / 10);

   localparam logic FIELD_HOURS   = 1'b0;
   localparam logic FIELD_MINUTES = 1'b1;

   // Hours pair +1 in BCD, wrapping 23 -> 00; result is {tens, units}.
   function automatic logic [5:0] bcd_inc_hours(input logic [1:0] tens,
                                                input logic [3:0] units);
      logic [5:0] r;
      if (tens == H_TENS_MAX && units == H_UNITS_MAX)
         r = '0;
      else if (units == 4'd9)
         r = {tens + 2'd1, 4'd0};
      else
         r = {tens, units + 4'd1};
      return r;
   endfunction

   // Minutes pair +1 in BCD, wrapping 59 -> 00; result is {tens, units}.
   function automatic logic [7:0] bcd_inc_minutes(input logic [3:0] tens,
                                                  input logic [3:0] units);
      logic [7:0] r;
      if (units == 4'd9) begin
         if (tens == M_TENS_MAX)
            r = '0;
         else
            r = {tens + 4'd1, 4'd0};
      end else begin
         r = {tens, units + 4'd1};
      end
      return r;
   endfunction

endpackage

// File: rtl/time_set_ctrl_debounce.sv
// One raw button: 2-FF synchronizer, stable-sample debouncer, press pulse on 0->1.
module btn_debounce #(
   parameter int unsigned DEB_CYCLES = 3
) (
   input  logic clk,
   input  logic reset,
   input  logic btn,
   output logic press
);

   localparam int unsigned CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

   logic [1:0]    sync;
   logic          level;
   logic [CW-1:0] cnt;

   // Bring the asynchronous button into the clock domain.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         sync <= '0;
      else
         sync <= {sync[0], btn};
   end

   // Flip the debounced level after DEB_CYCLES consecutive differing samples;
   // the press pulse coincides with the cycle the level becomes 1.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         level <= 1'b0;
         cnt   <= '0;
         press <= 1'b0;
      end else begin
         press <= 1'b0;
         if (sync[1] == level) begin
            cnt <= '0;
         end else if (cnt == CW'(DEB_CYCLES - 1)) begin
            level <= sync[1];
            cnt   <= '0;
            press <= sync[1];
         end else begin
            cnt <= cnt + CW'(1);
         end
      end
   end

endmodule

// File: rtl/time_set_ctrl.sv
// Button-driven editor for the clock core's BCD time/alarm load interface.
module time_set_ctrl
   import time_set_ctrl_pkg::*;
#(
   parameter int unsigned DEB_CYCLES = 3,
   parameter int unsigned LD_CYCLES  = 2,
   parameter int unsigned TIMEOUT    = 600
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       btn_mode,
   input  logic       btn_inc,
   input  logic       btn_ok,
   input  logic       sel_alarm,
   output logic [1:0] H_in1,
   output logic [3:0] H_in0,
   output logic [3:0] M_in1,
   output logic [3:0] M_in0,
   output logic       LD_time,
   output logic       LD_alarm,
   output logic       edit_active,
   output logic       field
);

   localparam int unsigned TW = $clog2(TIMEOUT);
   localparam int unsigned LW = (LD_CYCLES > 1) ? $clog2(LD_CYCLES) : 1;

   logic mode_p, inc_p, ok_p;

   state_t        state, state_n;
   logic [1:0]    h1_n;
   logic [3:0]    h0_n, m1_n, m0_n;
   logic [TW-1:0] to_cnt, to_cnt_n;
   logic [LW-1:0] ld_cnt, ld_cnt_n;
   logic          ld_time_n, ld_alarm_n;
   logic [5:0]    hours_inc;
   logic [7:0]    minutes_inc;

   btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_mode (
      .clk(clk), .reset(reset), .btn(btn_mode), .press(mode_p));
   btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_inc (
      .clk(clk), .reset(reset), .btn(btn_inc), .press(inc_p));
   btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_ok (
      .clk(clk), .reset(reset), .btn(btn_ok), .press(ok_p));

   // Register state, edit values, counters and the load strobes.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         H_in1    <= '0;
         H_in0    <= '0;
         M_in1    <= '0;
         M_in0    <= '0;
         to_cnt   <= '0;
         ld_cnt   <= '0;
         LD_time  <= 1'b0;
         LD_alarm <= 1'b0;
      end else begin
         state    <= state_n;
         H_in1    <= h1_n;
         H_in0    <= h0_n;
         M_in1    <= m1_n;
         M_in0    <= m0_n;
         to_cnt   <= to_cnt_n;
         ld_cnt   <= ld_cnt_n;
         LD_time  <= ld_time_n;
         LD_alarm <= ld_alarm_n;
      end
   end

   // Next state with ok > mode > inc priority, inactivity timeout and strobe length.
   always_comb begin
      state_n     = state;
      h1_n        = H_in1;
      h0_n        = H_in0;
      m1_n        = M_in1;
      m0_n        = M_in0;
      to_cnt_n    = '0;
      ld_cnt_n    = ld_cnt;
      ld_time_n   = LD_time;
      ld_alarm_n  = LD_alarm;
      hours_inc   = bcd_inc_hours(H_in1, H_in0);
      minutes_inc = bcd_inc_minutes(M_in1, M_in0);
      case (state)
         IDLE: begin
            ld_time_n  = 1'b0;
            ld_alarm_n = 1'b0;
            if (mode_p)
               state_n = EDIT_H;
         end
         EDIT_H, EDIT_M: begin
            if (ok_p) begin
               state_n    = COMMIT;
               ld_cnt_n   = '0;
               ld_time_n  = !sel_alarm;
               ld_alarm_n = sel_alarm;
            end else if (mode_p) begin
               state_n = (state == EDIT_H) ? EDIT_M : EDIT_H;
            end else if (inc_p) begin
               if (state == EDIT_H)
                  {h1_n, h0_n} = hours_inc;
               else
                  {m1_n, m0_n} = minutes_inc;
            end else if (to_cnt == TW'(TIMEOUT - 1)) begin
               state_n = IDLE;
            end else begin
               to_cnt_n = to_cnt + TW'(1);
            end
         end
         COMMIT: begin
            if (ld_cnt == LW'(LD_CYCLES - 1)) begin
               state_n    = IDLE;
               ld_time_n  = 1'b0;
               ld_alarm_n = 1'b0;
            end else begin
               ld_cnt_n = ld_cnt + LW'(1);
            end
         end
         default: state_n = IDLE;
      endcase
   end

   assign edit_active = (state == EDIT_H) || (state == EDIT_M);
   assign field       = (state == EDIT_M) ? FIELD_MINUTES : FIELD_HOURS;

endmodule

// File: tb/tb_time_set_ctrl.sv
module tb_time_set_ctrl;

   localparam int unsigned DEB = 3;
   localparam int unsigned LDC = 2;
   localparam int unsigned TMO = 600;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       btn_mode = 1'b0, btn_inc = 1'b0, btn_ok = 1'b0, sel_alarm = 1'b0;
   logic [1:0] H_in1;
   logic [3:0] H_in0, M_in1, M_in0;
   logic       LD_time, LD_alarm, edit_active, field;

   int checks = 0;
   int errors = 0;
   int ld_time_cnt = 0, ld_alarm_cnt = 0, edit_cnt = 0;
   bit both_seen = 1'b0;

   // reference model: time as plain integers, edit mode as two flags
   int m_h = 0, m_m = 0;
   bit m_edit = 1'b0, m_fld = 1'b0;

   always #5 clk = ~clk;

   time_set_ctrl #(.DEB_CYCLES(DEB), .LD_CYCLES(LDC), .TIMEOUT(TMO)) dut (
      .clk(clk), .reset(reset), .btn_mode(btn_mode), .btn_inc(btn_inc), .btn_ok(btn_ok),
      .sel_alarm(sel_alarm), .H_in1(H_in1), .H_in0(H_in0), .M_in1(M_in1), .M_in0(M_in0),
      .LD_time(LD_time), .LD_alarm(LD_alarm), .edit_active(edit_active), .field(field));

   // cycle counts of strobe/edit activity sampled mid-cycle
   always @(negedge clk) begin
      if (LD_time) ld_time_cnt++;
      if (LD_alarm) ld_alarm_cnt++;
      if (edit_active) edit_cnt++;
      if (LD_time && LD_alarm) both_seen = 1'b1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] all_out();
      return {18'd0, H_in1, H_in0, M_in1, M_in0, LD_time, LD_alarm, edit_active, field};
   endfunction

   task automatic check_model(input string tag);
      chk({tag, ":H_in1"}, H_in1, m_h / 10);
      chk({tag, ":H_in0"}, H_in0, m_h % 10);
      chk({tag, ":M_in1"}, M_in1, m_m / 10);
      chk({tag, ":M_in0"}, M_in0, m_m % 10);
      chk({tag, ":edit_active"}, edit_active, m_edit);
      if (m_edit) chk({tag, ":field"}, field, m_fld);
   endtask

   // press and release buttons together, then update the model and compare
   task automatic press(input bit ok, input bit mode, input bit inc, input string tag);
      int t0, a0, et, ea;
      t0 = ld_time_cnt;
      a0 = ld_alarm_cnt;
      @(negedge clk);
      btn_ok = ok; btn_mode = mode; btn_inc = inc;
      repeat (DEB + 3 + $urandom_range(0, 4)) @(negedge clk);
      btn_ok = 1'b0; btn_mode = 1'b0; btn_inc = 1'b0;
      repeat (DEB + 6 + $urandom_range(0, 4)) @(negedge clk);
      et = 0; ea = 0;
      if (!m_edit) begin
         if (mode) begin m_edit = 1'b1; m_fld = 1'b0; end
      end else if (ok) begin
         m_edit = 1'b0;
         if (sel_alarm) ea = LDC; else et = LDC;
      end else if (mode) begin
         m_fld = !m_fld;
      end else if (inc) begin
         if (m_fld) m_m = (m_m + 1) % 60; else m_h = (m_h + 1) % 24;
      end
      chk({tag, ":LD_time_cycles"}, ld_time_cnt - t0, et);
      chk({tag, ":LD_alarm_cycles"}, ld_alarm_cnt - a0, ea);
      check_model(tag);
   endtask

   task automatic set_time(input int h, input int m);
      press(0, 1, 0, "preset_mode");
      repeat ((h - m_h + 24) % 24) press(0, 0, 1, "preset_inc_h");
      press(0, 1, 0, "preset_mode2");
      repeat ((m - m_m + 60) % 60) press(0, 0, 1, "preset_inc_m");
      sel_alarm = 1'b0;
      press(1, 0, 0, "preset_ok");
   endtask

   initial begin
      int e0, t0, a0, r;
      bit found;

      // reset and quiet period
      repeat (3) @(negedge clk);
      chk("in_reset_outputs", all_out(), 0);
      reset = 1'b1;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         chk("idle_outputs", all_out(), 0);
      end

      // short glitches on mode must not start an edit
      e0 = edit_cnt;
      btn_mode = 1'b1; @(negedge clk); btn_mode = 1'b0;
      repeat (10) @(negedge clk);
      btn_mode = 1'b1; repeat (DEB - 1) @(negedge clk); btn_mode = 1'b0;
      repeat (15) @(negedge clk);
      chk("glitch_no_edit", edit_cnt - e0, 0);

      // ignored presses in idle, then 03:12 into time
      press(0, 0, 1, "idle_inc");
      press(1, 0, 0, "idle_ok");
      press(0, 1, 0, "s1_mode");
      repeat (3) press(0, 0, 1, "s1_inc_h");
      press(0, 1, 0, "s1_mode2");
      repeat (12) press(0, 0, 1, "s1_inc_m");
      sel_alarm = 1'b0;
      press(1, 0, 0, "s1_ok");
      chk("s1_value_0312", {H_in1, H_in0, M_in1, M_in0}, {18'd0, 2'd0, 4'd3, 4'd1, 4'd2});

      // wrap from 23:59 to 00:00 and load alarm
      set_time(23, 59);
      press(0, 1, 0, "wrap_mode");
      press(0, 0, 1, "wrap_inc_h");
      press(0, 1, 0, "wrap_mode2");
      press(0, 0, 1, "wrap_inc_m");
      sel_alarm = 1'b1;
      press(1, 0, 0, "wrap_ok");
      chk("wrap_value_0000", {H_in1, H_in0, M_in1, M_in0}, 0);

      // same-cycle events
      press(0, 1, 0, "sc_mode");
      press(0, 1, 0, "sc_mode2");
      press(0, 0, 1, "sc_inc_m");
      sel_alarm = 1'b0;
      press(1, 0, 1, "sc_ok_inc");
      press(0, 1, 0, "sc_mode3");
      press(0, 1, 1, "sc_mode_inc");
      press(0, 0, 1, "sc_inc_after");
      press(1, 0, 0, "sc_ok");

      // inactivity timeout keeps the edited value and loads nothing
      press(0, 1, 0, "to_mode");
      press(0, 0, 1, "to_inc");
      t0 = ld_time_cnt; a0 = ld_alarm_cnt;
      repeat (TMO - 40) @(negedge clk);
      chk("to_still_editing", edit_active, 1);
      repeat (60) @(negedge clk);
      chk("to_expired", edit_active, 0);
      chk("to_no_ld_time", ld_time_cnt - t0, 0);
      chk("to_no_ld_alarm", ld_alarm_cnt - a0, 0);
      m_edit = 1'b0;
      check_model("to_after");
      press(0, 1, 0, "to_mode2");
      press(0, 0, 1, "to_inc2");
      press(1, 0, 0, "to_ok2");

      // randomized button sequence
      for (int i = 0; i < 80; i++) begin
         sel_alarm = 1'($urandom_range(0, 1));
         r = $urandom_range(0, 9);
         if (!m_edit) begin
            if (r < 7) press(0, 1, 0, "rnd_mode");
            else if (r < 9) press(0, 0, 1, "rnd_idle_inc");
            else press(1, 0, 0, "rnd_idle_ok");
         end else begin
            if (r < 6) press(0, 0, 1, "rnd_inc");
            else if (r < 8) press(0, 1, 0, "rnd_mode");
            else press(1, 0, 0, "rnd_ok");
         end
      end

      // reset inside the strobe truncates it at once
      if (!m_edit) press(0, 1, 0, "rs_mode");
      sel_alarm = 1'b1;
      @(negedge clk);
      btn_ok = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 30 && !found; i++) begin
         @(negedge clk);
         if (LD_alarm) found = 1'b1;
      end
      chk("rs_strobe_started", found, 1);
      #2 reset = 1'b0;
      #1 chk("rs_outputs_cleared", all_out(), 0);
      btn_ok = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      m_h = 0; m_m = 0; m_edit = 1'b0; m_fld = 1'b0;
      repeat (DEB + 10) @(negedge clk);
      chk("rs_after_release", all_out(), 0);
      check_model("rs_after");

      chk("never_both_strobes", both_seen, 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/time_set_ctrl.md
# time_set_ctrl

Push-button front end that produces the time/alarm load interface of the alarm clock core. Three raw buttons are synchronized and debounced, an edit state machine lets the user step hours (00–23) and minutes (00–59) in BCD, and a commit drives H_in1/H_in0/M_in1/M_in0 with a registered LD_time or LD_alarm pulse. It sits between the board buttons and the clock core's load ports, on the same clock.

## Interface
- DEB_CYCLES, 3, consecutive stable synchronized samples required to accept a button level change (≥1)
- LD_CYCLES, 2, cycles LD_time/LD_alarm is held high on commit (≥1)
- TIMEOUT, 600, idle cycles in an edit state before abort without load (≥2)
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-low; clears all state
- btn_mode  in  1  raw, asynchronous; enter edit / toggle field
- btn_inc  in  1  raw, asynchronous; increment selected field
- btn_ok  in  1  raw, asynchronous; commit
- sel_alarm  in  1  level; 1 = commit loads alarm, 0 = loads time
- H_in1  out  2  hours tens BCD
- H_in0  out  4  hours units BCD
- M_in1  out  4  minutes tens BCD
- M_in0  out  4  minutes units BCD
- LD_time  out  1  time load strobe
- LD_alarm  out  1  alarm load strobe
- edit_active  out  1  high in EDIT_H/EDIT_M
- field  out  1  0 = hours selected, 1 = minutes selected (valid while edit_active)

## Operation
- Each button: 2-FF synchronizer, then debouncer; debounced level flips only after DEB_CYCLES consecutive synchronized samples differ from it. Press event = one-cycle pulse on debounced 0→1. Release generates nothing; holding does not repeat.
- States: IDLE, EDIT_H, EDIT_M, COMMIT.
- IDLE: mode → EDIT_H. inc/ok ignored.
- EDIT_H: inc → hours +1; mode → EDIT_M; ok → COMMIT.
- EDIT_M: inc → minutes +1; mode → EDIT_H; ok → COMMIT.
- COMMIT: strobe selected by sel_alarm sampled in the cycle ok is accepted; held LD_CYCLES cycles; then IDLE. All presses ignored in COMMIT.
- Timeout: inactivity counter cleared on any accepted press; reaching TIMEOUT in an edit state → IDLE, no strobe, registers keep edited values.
- Same-cycle events: priority ok > mode > inc; lower-priority events that cycle are dropped.
- BCD arithmetic: hours pair 23 → 00, H_in0 9 → 0 with carry into H_in1; minutes 59 → 00, M_in0 9 → 0 with carry. No binary intermediate; values are never outside 00–23 / 00–59.
- Edit registers persist across edits (next edit starts from last value).
- Outputs H_in*/M_in* always reflect edit registers; stable throughout COMMIT.
- Reset values: H_in1=0, H_in0=0, M_in1=0, M_in0=0, LD_time=0, LD_alarm=0, edit_active=0, field=0, state IDLE, debounced levels 0. Reset mid-COMMIT truncates the strobe immediately (asynchronous).

## Timing
- Raw button rising and held from cycle N: press pulse in cycle N+2+DEB_CYCLES (±1 for sampling phase); glitches shorter than DEB_CYCLES cycles after sync produce no event.
- Press pulse in cycle P → state/register update visible at clock edge ending P (visible in P+1).
- ok accepted in cycle P: strobe high cycles P+1 … P+LD_CYCLES, edit_active low from P+1, IDLE at P+LD_CYCLES+1.
- LD_time and LD_alarm never high simultaneously; both registered outputs, glitch-free.

## Structure
- Shared package: state enum (IDLE, EDIT_H, EDIT_M, COMMIT), BCD limit constants (HOURS_MAX=23, MINUTES_MAX=59), field encoding.
- One sub-module: btn_debounce (synchronizer + DEB_CYCLES counter + edge pulse), instantiated three times.
- Top holds FSM, BCD incrementers, timeout counter, strobe counter.

## Test plan
- Reset release, no buttons → all outputs 0, state IDLE for 100 cycles; 1-cycle and DEB_CYCLES−1 glitches on btn_mode produce no edit_active.
- mode, inc×3, mode, inc×12, ok with sel_alarm=0 → H_in=03, M_in=12, LD_time high exactly LD_CYCLES cycles, LD_alarm stays 0.
- Preset 23:59; mode, inc, mode, inc, ok, sel_alarm=1 → 00:00, LD_alarm strobe, no LD_time.
- In EDIT_M, ok and inc pressed same cycle → commit with minutes unchanged; mode+inc same cycle → field toggles, value unchanged.
- Enter edit, inc once, wait TIMEOUT cycles → IDLE, no strobe, edited value retained; next edit starts from it.
- Assert reset during cycle 1 of a 2-cycle strobe → strobe drops asynchronously, all outputs 0, IDLE after release.
